// File: rtl/cpu_nibble_serial_alu.sv
// cpu_nibble_serial_alu
// ---------------------------------------------------------------------------
// Multi-cycle ALU for the CPU datapath. It works through one 4-bit nibble per
// clock, so any multiple-of-4 operand width shares a single nibble adder.
// It supports binary/BCD ADC and SBC, AND/ORA/EOR, and ASL/LSR/ROL/ROR.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_valid / o_ready   request handshake; operands are captured on accept
//   i_op                operation (alu_op_t)
//   i_lhs, i_rhs        operands; i_rhs is the true subtrahend for SBC
//   i_carry             carry in (NOT borrow for SBC)
//   i_bcd               decimal mode, only used by ADC/SBC
//   o_valid / i_ready   result handshake; outputs hold while waiting
//   o_result            WIDTH-bit result
//   o_carry             carry out
//   o_overflow          signed overflow
//   o_zero              o_result == 0
//   o_negative          o_result MSB
// ---------------------------------------------------------------------------

package cpu_nibble_serial_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADC = 4'd0,
        OP_SBC = 4'd1,
        OP_AND = 4'd2,
        OP_ORA = 4'd3,
        OP_EOR = 4'd4,
        OP_ASL = 4'd5,
        OP_LSR = 4'd6,
        OP_ROL = 4'd7,
        OP_ROR = 4'd8
    } alu_op_t;

endpackage

module cpu_nibble_serial_alu
    import cpu_nibble_serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  alu_op_t          i_op,
    input  logic [WIDTH-1:0] i_lhs,
    input  logic [WIDTH-1:0] i_rhs,
    input  logic             i_carry,
    input  logic             i_bcd,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_zero,
    output logic             o_negative
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = $clog2(NIB);

    // Refuse to build for widths the nibble slicing cannot handle.
    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_width_check
        $error("cpu_nibble_serial_alu: WIDTH must be a multiple of 4 and at least 8");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    alu_op_t          op_q;
    logic [WIDTH-1:0] lhs_q, rhs_q, res_q, result_q;
    logic             cin_q, bcd_q, chain_q;
    logic             carry_q, overflow_q;

    logic             last_nib;
    logic             msb_first;
    logic [CW-1:0]    nib_idx;
    logic [3:0]       nib_a, nib_b, digit;
    logic [4:0]       sum5;
    logic             chain_d, carry_d, ovf_d, b_msb;
    logic [WIDTH-1:0] res_d;

    assign last_nib  = (cnt_q == CW'(NIB - 1));
    // Right shifts must see the higher nibble first so its low bit can feed
    // the next nibble down through the chain bit.
    assign msb_first = (op_q == OP_LSR) || (op_q == OP_ROR);
    assign nib_idx   = msb_first ? (CW'(NIB - 1) - cnt_q) : cnt_q;
    assign nib_a     = lhs_q[{nib_idx, 2'b00} +: 4];
    assign nib_b     = rhs_q[{nib_idx, 2'b00} +: 4];

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, run NIB nibbles, hold until consumed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_valid)  state_d = S_RUN;
            S_RUN:   if (last_nib) state_d = S_DONE;
            S_DONE:  if (i_ready)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One-nibble datapath. The chain bit is the carry for arithmetic and the
    // bit crossing the nibble boundary for shifts and rotates.
    always_comb begin
        sum5    = 5'd0;
        digit   = 4'd0;
        chain_d = 1'b0;
        carry_d = 1'b0;
        case (op_q)
            OP_ADC: begin
                sum5 = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0, chain_q};
                if (bcd_q) begin
                    chain_d = (sum5 > 5'd9);
                    digit   = chain_d ? (sum5[3:0] + 4'd6) : sum5[3:0];
                end else begin
                    chain_d = sum5[4];
                    digit   = sum5[3:0];
                end
                carry_d = chain_d;
            end
            OP_SBC: begin
                sum5    = {1'b0, nib_a} + {1'b0, ~nib_b} + {4'b0, chain_q};
                chain_d = sum5[4];
                digit   = (bcd_q && !sum5[4]) ? (sum5[3:0] - 4'd6) : sum5[3:0];
                carry_d = chain_d;
            end
            OP_AND: begin
                digit   = nib_a & nib_b;
                carry_d = cin_q;
            end
            OP_ORA: begin
                digit   = nib_a | nib_b;
                carry_d = cin_q;
            end
            OP_EOR: begin
                digit   = nib_a ^ nib_b;
                carry_d = cin_q;
            end
            OP_ASL, OP_ROL: begin
                digit   = {nib_a[2:0], chain_q};
                chain_d = nib_a[3];
                carry_d = chain_d;
            end
            OP_LSR, OP_ROR: begin
                digit   = {chain_q, nib_a[3:1]};
                chain_d = nib_a[0];
                carry_d = chain_d;
            end
            default: begin
                digit   = 4'd0;
                chain_d = 1'b0;
                carry_d = 1'b0;
            end
        endcase

        res_d = res_q;
        res_d[{nib_idx, 2'b00} +: 4] = digit;
    end

    // Signed overflow uses the uncorrected binary top-nibble sum even in BCD
    // mode; it is only meaningful on the last (top) nibble of ADC/SBC.
    assign b_msb = (op_q == OP_SBC) ? ~rhs_q[WIDTH-1] : rhs_q[WIDTH-1];
    assign ovf_d = ((op_q == OP_ADC) || (op_q == OP_SBC))
                   && (lhs_q[WIDTH-1] == b_msb)
                   && (sum5[3] != lhs_q[WIDTH-1]);

    // Operand capture on accept, nibble stepping during RUN, and the result
    // registers that are loaded only on the final nibble so they hold steady
    // through DONE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q      <= '0;
            op_q       <= OP_ADC;
            lhs_q      <= '0;
            rhs_q      <= '0;
            cin_q      <= 1'b0;
            bcd_q      <= 1'b0;
            chain_q    <= 1'b0;
            res_q      <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE && i_valid) begin
                cnt_q   <= '0;
                op_q    <= i_op;
                lhs_q   <= i_lhs;
                rhs_q   <= i_rhs;
                cin_q   <= i_carry;
                bcd_q   <= i_bcd;
                chain_q <= (i_op == OP_ASL || i_op == OP_LSR) ? 1'b0 : i_carry;
                res_q   <= '0;
            end else if (state_q == S_RUN) begin
                cnt_q   <= cnt_q + 1'b1;
                chain_q <= chain_d;
                res_q   <= res_d;
                if (last_nib) begin
                    result_q   <= res_d;
                    carry_q    <= carry_d;
                    overflow_q <= ovf_d;
                end
            end
        end
    end

    assign o_ready    = (state_q == S_IDLE);
    assign o_valid    = (state_q == S_DONE);
    assign o_result   = result_q;
    assign o_carry    = carry_q;
    assign o_overflow = overflow_q;
    assign o_zero     = (result_q == '0);
    assign o_negative = result_q[WIDTH-1];

endmodule
